// File: rtl/snn_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : snn_frame_loader
//  Purpose  : Assembles paged mailbox words into a PIXELS-wide image register.
//             After the final page it issues a start pulse and a bounded
//             window of spike-clock enables, then latches the network output.
//             Pages that do not fit the image set a sticky overflow flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLK        in   1          system clock
//    iRESETn     in   1          asynchronous active-low reset
//    iPAGE_DATA  in   PAGE_BITS  page, word k at [k*WORD_W +: WORD_W]
//    iNEXT       in   1          host page-valid level (asynchronous)
//    iFINISH     in   1          current page is the last of the frame
//    oACK        out  1          page accepted
//    oPIXELS     out  PIXELS     assembled image
//    oSTART      out  1          one-cycle network start pulse
//    oSPIKE_EN   out  1          spike clock enable
//    iNEURON     in   OUT_W      network outputs
//    oRESULT     out  OUT_W      latched result
//    oDONE       out  1          result valid
//    oBUSY       out  1          final page acknowledged, start or run
//    oOVERFLOW   out  1          sticky: page beyond capacity received
// ============================================================================
module snn_frame_loader #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_PAGE = 14,
    parameter int PIXELS         = 800,
    parameter int RUN_CYCLES     = 16,
    parameter int OUT_W          = 2
) (
    input  logic                               iCLK,
    input  logic                               iRESETn,
    input  logic [WORD_W*WORDS_PER_PAGE-1:0]   iPAGE_DATA,
    input  logic                               iNEXT,
    input  logic                               iFINISH,
    output logic                               oACK,
    output logic [PIXELS-1:0]                  oPIXELS,
    output logic                               oSTART,
    output logic                               oSPIKE_EN,
    input  logic [OUT_W-1:0]                   iNEURON,
    output logic [OUT_W-1:0]                   oRESULT,
    output logic                               oDONE,
    output logic                               oBUSY,
    output logic                               oOVERFLOW
);

    localparam int PAGE_BITS = WORD_W * WORDS_PER_PAGE;
    localparam int NUM_PAGES = (PIXELS + PAGE_BITS - 1) / PAGE_BITS;
    localparam int PAGE_W    = $clog2(NUM_PAGES + 1);
    localparam int CNT_W     = $clog2(RUN_CYCLES + 1);

    localparam logic [PAGE_W-1:0] c_numPages  = PAGE_W'(NUM_PAGES);
    localparam logic [CNT_W-1:0]  c_runCycles = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0]  c_runLast   = CNT_W'(1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_ACK   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_stateNext;
    logic              r_nxtMeta;
    logic              r_nxtSync;
    logic [PAGE_W-1:0] r_pageIdx;
    logic              r_final;
    logic [CNT_W-1:0]  r_runCnt;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_result;
    logic              r_ack;
    logic              r_done;
    logic              r_ovf;
    logic [PIXELS-1:0] r_pixels;
    logic [PIXELS-1:0] w_pixNext;
    logic [PAGE_W-1:0] w_page;
    logic              w_accept;
    logic              w_ackRelease;
    logic              w_runLast;

    // Two-flop synchroniser for the host's page-valid level.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_nxtMeta <= 1'b0;
            r_nxtSync <= 1'b0;
        end else begin
            r_nxtMeta <= iNEXT;
            r_nxtSync <= r_nxtMeta;
        end
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_stateNext  = r_state;
        w_accept     = 1'b0;
        w_ackRelease = 1'b0;
        w_runLast    = 1'b0;
        case (r_state)
            S_LOAD, S_DONE: begin
                if (r_nxtSync) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_ACK;
                end
            end
            S_ACK: begin
                if (!r_nxtSync) begin
                    w_ackRelease = 1'b1;
                    w_stateNext  = r_final ? S_START : S_LOAD;
                end
            end
            S_START: begin
                w_stateNext = S_RUN;
            end
            S_RUN: begin
                if (r_runCnt == c_runLast) begin
                    w_runLast   = 1'b1;
                    w_stateNext = S_DONE;
                end
            end
            default: begin
                w_stateNext = S_LOAD;
            end
        endcase
    end

    // An accept out of S_DONE opens a new frame, so it always targets page 0.
    assign w_page = (r_state == S_DONE) ? '0 : r_pageIdx;

    // Per-pixel next value: take the page bit when this pixel belongs to the
    // page being accepted, clear it when page 0 opens a frame, else hold.
    // Pages at or beyond capacity match no pixel and are discarded.
    for (genvar i = 0; i < PIXELS; i++) begin : g_pix
        localparam int                PG   = i / PAGE_BITS;
        localparam int                BT   = i % PAGE_BITS;
        localparam logic [PAGE_W-1:0] c_pg = PAGE_W'(PG);
        assign w_pixNext[i] = (w_page == c_pg) ? iPAGE_DATA[BT] :
                              ((w_page == '0) ? 1'b0 : r_pixels[i]);
    end

    // Datapath registers.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_pixels  <= '0;
            r_pageIdx <= '0;
            r_final   <= 1'b0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_runCnt  <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_pixels <= w_pixNext;
                if (w_page >= c_numPages) begin
                    r_ovf <= 1'b1;
                end
                r_pageIdx <= (w_page < c_numPages) ? (w_page + 1'b1) : w_page;
                r_final   <= iFINISH;
                r_ack     <= 1'b1;
                r_done    <= 1'b0;
            end
            if (w_ackRelease) begin
                r_ack <= 1'b0;
                if (r_final) begin
                    r_pageIdx <= '0;
                end
            end
            if (r_state == S_START) begin
                r_result <= '0;
                r_acc    <= '0;
                r_runCnt <= c_runCycles;
            end
            if (r_state == S_RUN) begin
                r_acc    <= r_acc | iNEURON;
                r_runCnt <= r_runCnt - 1'b1;
                // Fold in the last enable cycle's sample directly.
                if (w_runLast) begin
                    r_result <= r_acc | iNEURON;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    // Decoded from the state register so reset removes them immediately.
    assign oSTART    = (r_state == S_START);
    assign oSPIKE_EN = (r_state == S_RUN);
    assign oBUSY     = ((r_state == S_ACK) && r_final) || (r_state == S_START) ||
                       (r_state == S_RUN);
    assign oACK      = r_ack;
    assign oPIXELS   = r_pixels;
    assign oRESULT   = r_result;
    assign oDONE     = r_done;
    assign oOVERFLOW = r_ovf;

endmodule
`default_nettype wire

// File: doc/snn_frame_loader.md
# snn_frame_loader

Parametrised frame assembler and run sequencer between the JTAG mailbox (paged 32-bit words plus NEXT/FINISH flags) and the spiking-network core. It accepts any number of pages through a four-phase handshake and packs them into a PIXELS-wide image register. After the final page it issues a single-cycle start pulse and a bounded run window of spike-clock enables. It then latches the network's output. It also detects capacity overflow.

## Interface
- WORD_W, 32, bits per mailbox word
- WORDS_PER_PAGE, 14, words per page; PAGE_BITS = WORD_W*WORDS_PER_PAGE
- PIXELS, 800, image width; NUM_PAGES = ceil(PIXELS/PAGE_BITS)
- RUN_CYCLES, 16, spike-enable cycles per run (>=1)
- OUT_W, 2, neuron output width

- iCLK  in  1  system clock
- iRESETn  in  1  asynchronous active-low reset
- iPAGE_DATA  in  PAGE_BITS  page; word k at [k*WORD_W +: WORD_W]
- iNEXT  in  1  host page-valid level (asynchronous to iCLK)
- iFINISH  in  1  marks current page as last of frame
- oACK  out  1  page accepted
- oPIXELS  out  PIXELS  assembled image
- oSTART  out  1  one-cycle network start pulse
- oSPIKE_EN  out  1  spike clock enable (replaces gated clock)
- iNEURON  in  OUT_W  network outputs
- oRESULT  out  OUT_W  latched result
- oDONE  out  1  result valid
- oBUSY  out  1  high in S_ACK-final, S_START, S_RUN
- oOVERFLOW  out  1  sticky: page beyond capacity received

## Operation
- iNEXT passes through a 2-flop synchroniser (nxt_s). iPAGE_DATA/iFINISH are sampled unsynchronised at the accept edge. The host holds them stable from iNEXT rise until oACK rise.
- States: S_LOAD, S_ACK, S_START, S_RUN, S_DONE. Reset -> S_LOAD, page_idx=0.
- Accept: in S_LOAD or S_DONE with nxt_s=1.
  - From S_DONE, the accept starts a new frame: page_idx treated as 0 and oDONE cleared.
  - Page p (=page_idx) writes oPIXELS[p*PAGE_BITS + b] for b < PAGE_BITS where the index < PIXELS. Bits >= PIXELS are dropped.
  - On accepting page 0, all oPIXELS bits outside page 0 are cleared.
  - If p >= NUM_PAGES: data discarded and oOVERFLOW set. Ack proceeds normally.
  - page_idx increments, saturating at NUM_PAGES. A final flag is stored from iFINISH. oACK=1 -> S_ACK.
- S_ACK: holds oACK=1 until nxt_s=0, then oACK=0.
  - If final: page_idx=0, -> S_START.
  - Otherwise: -> S_LOAD.
- S_START: oSTART=1 for one cycle, oRESULT cleared -> S_RUN.
- S_RUN: oSPIKE_EN=1 for exactly RUN_CYCLES cycles (down-counter, $clog2(RUN_CYCLES+1) bits).
  - Accumulator = OR of iNEURON on each cycle oSPIKE_EN=1.
  - After the last cycle, oRESULT = accumulator, oDONE=1 -> S_DONE.
- iNEXT rises during S_START/S_RUN: not accepted until S_DONE (level held pending). No page is lost if the host keeps iNEXT high.
- oOVERFLOW clears only on reset.
- Reset asserted at any time: all outputs 0, state S_LOAD, counters 0, synchroniser cleared. oSPIKE_EN drops asynchronously.

## Timing
- Reset values: oACK, oPIXELS, oSTART, oSPIKE_EN, oRESULT, oDONE, oBUSY, oOVERFLOW all 0.
- Accept latency:
  - Edge 1: iNEXT first sampled high.
  - Edge 2: nxt_s high.
  - Edge 3: accept. oPIXELS and oACK are updated and visible after edge 3.
- oACK falls on the 3rd edge after iNEXT is first sampled low.
- Final page: oSTART high in the cycle after oACK falls. oSPIKE_EN high on the next RUN_CYCLES cycles. oRESULT/oDONE valid on the edge ending the last enable cycle.
- iNEURON is sampled on edges where oSPIKE_EN=1 only.
- One accept per iNEXT high phase regardless of duration.
- Minimum frame: 1 page, total iNEXT-rise to oDONE = 3 + ack-release + 1 + RUN_CYCLES cycles.

## Test plan
- Defaults, two pages: page0 word k = 32'h1000_0000+k with FINISH=0; page1 word k = 32'h2000_0000+k with FINISH=1 -> oPIXELS[31:0]=32'h1000_0000, oPIXELS[479:448]=32'h2000_0000, oPIXELS[799:768]=32'h2000_000A; page1 words 11–13 dropped; oSTART exactly 1 cycle; oSPIKE_EN exactly 16 cycles.
- Frame of all-ones pages, then one-page frame with FINISH=1 and zero data -> oPIXELS==0 (page-0 clear); oDONE re-asserts.
- iNEURON=2'b01 for one cycle at run cycle 5, 2'b10 one cycle after run ends -> oRESULT=2'b01, oDONE=1.
- PIXELS=800: pages 0 and 1 FINISH=0, page 2 FINISH=1 with data 32'hFFFF_FFFF -> oOVERFLOW=1, oPIXELS unchanged by page 2, run still starts.
- iNEXT held high 20 cycles -> exactly one accept (page_idx +1), oACK high until 3 edges after iNEXT low.
- iRESETn low in run cycle 8 -> oSPIKE_EN, oBUSY, oDONE, oPIXELS, oOVERFLOW all 0 immediately; next two-page frame reproduces the first scenario.
